memory_arbiter: RTL

Shares the single main-memory block port between the instruction cache (read-only refills) and the data cache (refills and write-backs). Sits between `icache`/`dcache` and main memory; each cache sees a private memory port with the usual read/write/busywait handshake. Grants one transaction at a time with round-robin priority, latches the winning request for the whole transaction, and routes completion back to the owner.

---
 rtl/memory_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// memory_arbiter
//
// Shares one main-memory block port between the instruction cache
// (read-only refills) and the data cache (refills and write-backs).
// One transaction runs at a time. Grants use round-robin priority.
// The winning request is latched for the whole transaction, and
// completion is routed back to its owner.
//
// Ports
//   clock            rising-edge system clock
//   reset            asynchronous, active-low; 0 forces the idle state
//   i_mem_read       icache refill request (level)
//   i_mem_address    icache block address
//   i_mem_readdata   refill data to icache (valid in its done cycle)
//   i_mem_busywait   icache stall
//   d_mem_read       dcache refill request (level)
//   d_mem_write      dcache write-back request (level)
//   d_mem_address    dcache block address
//   d_mem_writedata  dcache write-back data
//   d_mem_readdata   refill data to dcache (valid in its done cycle)
//   d_mem_busywait   dcache stall
//   mem_read         registered main-memory read request
//   mem_write        registered main-memory write request
//   mem_address      latched main-memory block address
//   mem_writedata    latched main-memory write data
//   mem_readdata     main-memory read data
//   mem_busywait     main-memory busy
module memory_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  i_mem_read,
    input  logic [ADDR_WIDTH-1:0] i_mem_address,
    output logic [DATA_WIDTH-1:0] i_mem_readdata,
    output logic                  i_mem_busywait,

    input  logic                  d_mem_read,
    input  logic                  d_mem_write,
    input  logic [ADDR_WIDTH-1:0] d_mem_address,
    input  logic [DATA_WIDTH-1:0] d_mem_writedata,
    output logic [DATA_WIDTH-1:0] d_mem_readdata,
    output logic                  d_mem_busywait,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    input  logic                  mem_busywait
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t                state;
    state_t                next_state;
    logic                  last_grant;   // 0 = icache, 1 = dcache
    logic                  started;
    logic                  lat_read;
    logic                  lat_write;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;
    logic done;

    // Request decode and grant decision. On a tie the side that did not
    // win last time is chosen, so contention strictly alternates.
    // started can only be set while a grant is active. The state qualifier
    // keeps done tied to the grant states.
    always_comb begin
        i_req   = i_mem_read;
        d_req   = d_mem_read | d_mem_write;
        grant_i = (state == IDLE) & i_req & (~d_req | last_grant);
        grant_d = (state == IDLE) & d_req & (~i_req | ~last_grant);
        done    = (state != IDLE) & started & ~mem_busywait;
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_i) begin
                    next_state = GRANT_I;
                end else if (grant_d) begin
                    next_state = GRANT_D;
                end
            end
            GRANT_I, GRANT_D: begin
                if (done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Transaction latches. The request flags are cleared on the done edge,
    // so memory sees at least one idle cycle between transactions. A dcache
    // request with both read and write high is handled as a write-back.
    // started records that memory has acknowledged with busywait. Completion
    // is only recognised after that acknowledgement.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
            started    <= 1'b0;
            lat_read   <= 1'b0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else if (grant_i) begin
            last_grant <= 1'b0;
            started    <= 1'b0;
            lat_read   <= 1'b1;
            lat_write  <= 1'b0;
            lat_addr   <= i_mem_address;
        end else if (grant_d) begin
            last_grant <= 1'b1;
            started    <= 1'b0;
            lat_read   <= ~d_mem_write;
            lat_write  <= d_mem_write;
            lat_addr   <= d_mem_address;
            lat_wdata  <= d_mem_writedata;
        end else if (done) begin
            started    <= 1'b0;
            lat_read   <= 1'b0;
            lat_write  <= 1'b0;
        end else if ((state != IDLE) && mem_busywait) begin
            started    <= 1'b1;
        end
    end

    // Output logic. A requester stalls until its own transaction completes.
    // This includes the cycles in which it is pending or losing arbitration.
    always_comb begin
        mem_read       = lat_read;
        mem_write      = lat_write;
        mem_address    = lat_addr;
        mem_writedata  = lat_wdata;
        i_mem_readdata = mem_readdata;
        d_mem_readdata = mem_readdata;
        i_mem_busywait = i_req & ~((state == GRANT_I) & done);
        d_mem_busywait = d_req & ~((state == GRANT_D) & done);
    end

endmodule
